// File: rtl/avl_mem_responder.sv
// avl_mem_responder: block-RAM backed Avalon-MM responder with the same local
// interface as the fpga_ddr3 controller (avl_* plus local_init_done).
//
// Optional feature macro: AVL_BACKPRESSURE_EN
//   defined   -> a free-running 2-bit counter drops avl_ready every 4th cycle
//   undefined -> avl_ready follows the FSM only
//
// Handshake: a request (IDLE) or write beat (WRITE_BURST) is taken at a rising
// edge exactly when avl_ready is high during the preceding cycle and the
// corresponding request line is high; the master must hold it otherwise.
// Read beats come back on avl_rdata_valid with no ready from the master.
//
// fsm_state exposes the controller state for debug and checker binding.
module avl_mem_responder #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 128,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 3,
  parameter int INIT_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    local_init_done,
  output logic                    avl_ready,
  input  logic                    avl_burstbegin,
  input  logic [ADDR_WIDTH-1:0]   avl_addr,
  input  logic                    avl_read_req,
  input  logic                    avl_write_req,
  input  logic [2:0]              avl_size,
  input  logic [DATA_WIDTH-1:0]   avl_wdata,
  input  logic [DATA_WIDTH/8-1:0] avl_be,
  output logic [DATA_WIDTH-1:0]   avl_rdata,
  output logic                    avl_rdata_valid,
  output logic [1:0]              fsm_state
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int INIT_W   = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT        = 2'd0,
    ST_IDLE        = 2'd1,
    ST_WRITE_BURST = 2'd2,
    ST_READ_ISSUE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
  logic                    init_done_q, init_done_d;
  logic [DEPTH_LOG2-1:0]   beat_addr_q, beat_addr_d;
  logic [2:0]              remain_q, remain_d;

  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic                    rd_issue;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic [2:0]              size_eff;
  logic                    bp_stall;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];

  // The start-of-burst marker and the upper address bits carry no meaning here;
  // addresses alias onto the backing store.
  logic unused_inputs;
  assign unused_inputs = ^{avl_burstbegin, avl_addr[ADDR_WIDTH-1:DEPTH_LOG2]};

  assign req_idx  = avl_addr[DEPTH_LOG2-1:0];
  assign size_eff = (avl_size == 3'd0) ? 3'd1 : avl_size;

`ifdef AVL_BACKPRESSURE_EN
  logic [1:0] bp_cnt_q;

  // Free-running phase counter; ready is withheld in its last phase.
  always_ff @(posedge clk) begin
    if (!reset_n) bp_cnt_q <= 2'd0;
    else          bp_cnt_q <= bp_cnt_q + 2'd1;
  end

  assign bp_stall = (bp_cnt_q == 2'd3);
`else
  assign bp_stall = 1'b0;
`endif

  assign avl_ready = ((state_q == ST_IDLE) || (state_q == ST_WRITE_BURST)) && !bp_stall;
  assign local_init_done = init_done_q;
  assign fsm_state = state_q;
  assign avl_rdata_valid = pipe_valid_q[READ_LATENCY-1];
  assign avl_rdata = pipe_data_q[READ_LATENCY-1];

  // State, init counter and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      beat_addr_q <= '0;
      remain_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      beat_addr_q <= beat_addr_d;
      remain_q    <= remain_d;
    end
  end

  // Next-state logic plus the per-cycle RAM write and read-issue strobes.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    beat_addr_d = beat_addr_q;
    remain_d    = remain_q;
    wr_en       = 1'b0;
    wr_idx      = beat_addr_q;
    rd_issue    = 1'b0;
    rd_idx      = beat_addr_q;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end

      ST_IDLE: begin
        if (avl_ready) begin
          if (avl_write_req) begin
            // Write wins when both request lines are high.
            wr_en  = 1'b1;
            wr_idx = req_idx;
            if (size_eff > 3'd1) begin
              state_d     = ST_WRITE_BURST;
              remain_d    = size_eff - 3'd1;
              beat_addr_d = req_idx + DEPTH_LOG2'(1);
            end
          end else if (avl_read_req) begin
            rd_issue = 1'b1;
            rd_idx   = req_idx;
            if (size_eff > 3'd1) begin
              state_d     = ST_READ_ISSUE;
              remain_d    = size_eff - 3'd1;
              beat_addr_d = req_idx + DEPTH_LOG2'(1);
            end
          end
        end
      end

      ST_WRITE_BURST: begin
        // Cycles without a write beat are wait states; read requests are ignored.
        if (avl_write_req && avl_ready) begin
          wr_en       = 1'b1;
          beat_addr_d = beat_addr_q + DEPTH_LOG2'(1);
          remain_d    = remain_q - 3'd1;
          if (remain_q == 3'd1) state_d = ST_IDLE;
        end
      end

      ST_READ_ISSUE: begin
        rd_issue    = 1'b1;
        beat_addr_d = beat_addr_q + DEPTH_LOG2'(1);
        remain_d    = remain_q - 3'd1;
        if (remain_q == 3'd1) state_d = ST_IDLE;
      end

      default: state_d = ST_INIT;
    endcase
  end

  // Backing store write port with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && reset_n) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (avl_be[b]) mem[wr_idx][8*b +: 8] <= avl_wdata[8*b +: 8];
      end
    end
  end

  // Read pipeline: RAM sampled at issue, then shifted READ_LATENCY-1 more times.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_valid_q[0] <= rd_issue;
      pipe_data_q[0]  <= rd_issue ? mem[rd_idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_data_q[i]  <= pipe_data_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_avl_mem_responder.sv
// tb_avl_mem_responder: randomized scoreboard bench for avl_mem_responder.
// Driver tasks push expected read beats (data and cycle) when a read is
// accepted; an independent monitor pops and compares on every valid beat.
module tb_avl_mem_responder;

  localparam int ADDR_WIDTH   = 26;
  localparam int DATA_WIDTH   = 128;
  localparam int DEPTH_LOG2   = 10;
  localparam int READ_LATENCY = 3;
  localparam int INIT_CYCLES  = 16;
  localparam int BE_WIDTH     = DATA_WIDTH / 8;
  localparam int DEPTH        = 1 << DEPTH_LOG2;

  logic                  clk;
  logic                  reset_n;
  logic                  local_init_done;
  logic                  avl_ready;
  logic                  avl_burstbegin;
  logic [ADDR_WIDTH-1:0] avl_addr;
  logic                  avl_read_req;
  logic                  avl_write_req;
  logic [2:0]            avl_size;
  logic [DATA_WIDTH-1:0] avl_wdata;
  logic [BE_WIDTH-1:0]   avl_be;
  logic [DATA_WIDTH-1:0] avl_rdata;
  logic                  avl_rdata_valid;
  logic [1:0]            fsm_state;

  avl_mem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2),
    .READ_LATENCY(READ_LATENCY), .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .local_init_done(local_init_done),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_size(avl_size),
    .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_rdata(avl_rdata),
    .avl_rdata_valid(avl_rdata_valid), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];
  int                    exp_cyc_q[$];
  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];
  logic [DATA_WIDTH-1:0] wq_data[$];
  logic [BE_WIDTH-1:0]   wq_be[$];

  task automatic chk(input logic ok, input string name,
                     input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input logic ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a write updates only the enabled bytes of one word.
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [BE_WIDTH-1:0] be);
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_WIDTH; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic int word_of(input logic [ADDR_WIDTH-1:0] addr, input int beat);
    return (int'(addr) + beat) % DEPTH;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (avl_rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk(1'b0 === avl_rdata_valid, "unexpected_rdata_valid", avl_rdata, '0);
      end else begin
        logic [DATA_WIDTH-1:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk(avl_rdata === e, "rdata", avl_rdata, e);
        chk_int(cyc == ec, "rdata_valid_cycle", cyc, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with the request already driven; returns 1 ps after
  // the accepting edge.
  task automatic wait_accept(output logic ok);
    logic rdy;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rdy = avl_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk_int(ok === 1'b1, "accept_timeout", int'(ok), 1);
  endtask

  task automatic clear_inputs();
    avl_burstbegin = 1'b0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_addr       = '0;
    avl_size       = 3'd0;
    avl_wdata      = '0;
    avl_be         = '0;
  endtask

  // Beats come from wq_data/wq_be; random wait states between beats.
  task automatic avl_write(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size,
                           input int max_gap);
    int n;
    int a;
    logic ok;
    n = (size == 3'd0) ? 1 : int'(size);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      avl_write_req  = 1'b1;
      avl_burstbegin = (i == 0);
      avl_addr       = addr;
      avl_size       = size;
      avl_wdata      = wq_data[i];
      avl_be         = wq_be[i];
      wait_accept(ok);
      avl_write_req  = 1'b0;
      avl_burstbegin = 1'b0;
      if (!ok) break;
      a = word_of(addr, i);
      ref_mem[a] = merge(ref_mem[a], wq_data[i], wq_be[i]);
    end
    wq_data.delete();
    wq_be.delete();
  endtask

  task automatic avl_read(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size);
    int n;
    int e;
    logic ok;
    n = (size == 3'd0) ? 1 : int'(size);
    @(negedge clk);
    avl_read_req   = 1'b1;
    avl_burstbegin = 1'b1;
    avl_addr       = addr;
    avl_size       = size;
    wait_accept(ok);
    avl_read_req   = 1'b0;
    avl_burstbegin = 1'b0;
    if (ok) begin
      e = cyc;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(ref_mem[word_of(addr, i)]);
        exp_cyc_q.push_back(e + i + READ_LATENCY - 1);
      end
      for (int i = 1; i < n; i++) begin
        @(negedge clk);
        chk_int(avl_ready === 1'b0, "ready_low_during_read_burst", int'(avl_ready), 0);
      end
      if (n > 1) begin
        @(negedge clk);
        chk_int(avl_ready === 1'b1, "ready_after_read_burst", int'(avl_ready), 1);
      end
    end
  endtask

  task automatic do_reset();
    int n;
    logic early;
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk_int(local_init_done === 1'b0, "reset_init_done", int'(local_init_done), 0);
    chk_int(avl_ready === 1'b0, "reset_ready", int'(avl_ready), 0);
    chk_int(avl_rdata_valid === 1'b0, "reset_rdata_valid", int'(avl_rdata_valid), 0);
    chk(avl_rdata === '0, "reset_rdata", avl_rdata, '0);
    // Anything still in flight when reset hit is never delivered.
    exp_q.delete();
    exp_cyc_q.delete();
    reset_n = 1'b1;
    n = 0;
    early = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (local_init_done === 1'b1) break;
      if (avl_ready !== 1'b0) early = 1'b1;
    end
    chk_int(n == INIT_CYCLES, "init_done_cycles", n, INIT_CYCLES);
    chk_int(early === 1'b0, "ready_during_init", int'(early), 0);
    chk_int(avl_ready === 1'b1, "ready_after_init", int'(avl_ready), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
    logic                  ok;
    int                    n;

    reset_n = 1'b0;
    clear_inputs();
    do_reset();

    // Fill the whole store so every later read has a defined reference value.
    for (int a = 0; a < DEPTH; a++) begin
      wq_data.push_back({$urandom, $urandom, $urandom, $urandom});
      wq_be.push_back('1);
      avl_write(ADDR_WIDTH'(a), 3'($urandom_range(0, 1)), 0);
    end

    // Single write then read-back at address 5.
    wq_data.push_back(128'h0123456789ABCDEF_0123456789ABCDEF);
    wq_be.push_back(16'hFFFF);
    avl_write(26'd5, 3'd1, 0);
    avl_read(26'd5, 3'd1);

    // Byte enables: clear bytes 4..7 of an all-ones word.
    wq_data.push_back('1);
    wq_be.push_back(16'hFFFF);
    avl_write(26'd7, 3'd1, 0);
    wq_data.push_back('0);
    wq_be.push_back(16'h00F0);
    avl_write(26'd7, 3'd0, 0);
    avl_read(26'd7, 3'd1);

    // Burst across the top of the store, wrapping to words 0 and 1.
    for (int i = 1; i <= 4; i++) begin
      wq_data.push_back(DATA_WIDTH'(i));
      wq_be.push_back(16'hFFFF);
    end
    avl_write(26'd1022, 3'd4, 2);
    avl_read(26'd1022, 3'd4);
    avl_read(26'd0, 3'd1);
    avl_read(26'd1, 3'd1);

    // Simultaneous read and write at an aliased address: only the write happens.
    @(negedge clk);
    avl_write_req = 1'b1;
    avl_read_req  = 1'b1;
    avl_addr      = 26'h400;
    avl_size      = 3'd1;
    avl_wdata     = {$urandom, $urandom, $urandom, $urandom};
    avl_be        = 16'hFFFF;
    wait_accept(ok);
    avl_write_req = 1'b0;
    avl_read_req  = 1'b0;
    if (ok) ref_mem[0] = merge(ref_mem[0], avl_wdata, avl_be);
    repeat (READ_LATENCY + 2) @(negedge clk);
    avl_read(26'd0, 3'd1);

    // Back-to-back single reads at one beat per cycle.
    for (int i = 0; i < 8; i++) avl_read(ADDR_WIDTH'($urandom), 3'd1);

    // Randomized mix of bursts, sizes, aliased addresses and wait states.
    for (int k = 0; k < 250; k++) begin
      addr = ADDR_WIDTH'($urandom);
      size = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        n = (size == 3'd0) ? 1 : int'(size);
        for (int i = 0; i < n; i++) begin
          wq_data.push_back({$urandom, $urandom, $urandom, $urandom});
          wq_be.push_back(BE_WIDTH'($urandom));
        end
        avl_write(addr, size, 2);
      end else begin
        avl_read(addr, size);
      end
    end

    // Drain outstanding reads before the reset test.
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);

    // Reset two cycles into a 4-beat read: none of its beats may appear.
    @(negedge clk);
    avl_read_req = 1'b1;
    avl_addr     = 26'd100;
    avl_size     = 3'd4;
    wait_accept(ok);
    avl_read_req = 1'b0;
    @(negedge clk);
    do_reset();

    // Store contents survive reset.
    avl_read(26'd5, 3'd1);
    avl_read(26'd1022, 3'd4);
    avl_read(26'd7, 3'd2);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    chk_int(exp_q.size() == 0, "outstanding_reads_at_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
